// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch stage control, loader and IF/ID signal bundle
interface if_stage_if;
    logic        i_stall;
    logic        i_branch_prediction;
    logic [31:0] i_branch_target_addr;
    logic        i_mispredict;
    logic [31:0] i_correct_pc;
    logic        i_imem_we;
    logic [31:0] i_imem_addr;
    logic [31:0] i_imem_wdata;
    logic [31:0] o_instruction;
    logic [31:0] o_next_pc;
    logic        o_valid;
    logic [31:0] o_pc;
    logic        o_halted;

    modport master (
        output i_stall, i_branch_prediction, i_branch_target_addr,
               i_mispredict, i_correct_pc, i_imem_we, i_imem_addr, i_imem_wdata,
        input  o_instruction, o_next_pc, o_valid, o_pc, o_halted
    );

    modport slave (
        input  i_stall, i_branch_prediction, i_branch_target_addr,
               i_mispredict, i_correct_pc, i_imem_we, i_imem_addr, i_imem_wdata,
        output o_instruction, o_next_pc, o_valid, o_pc, o_halted
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with local imem, IF/ID register and RUN/HALT FSM
module if_stage #(
    parameter int IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.slave   bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] instr, instr_nx;
    logic [31:0] next_pc, next_pc_nx;
    logic        valid, valid_nx;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] fetch_word;
    logic [31:0] pc_plus4;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{bus.i_imem_addr[31:AW+2], bus.i_imem_addr[1:0]};

    // Loader port has no reset so images can be preloaded while the core is held in reset.
    always_ff @(posedge clk) begin
        if (bus.i_imem_we)
            imem[bus.i_imem_addr[AW+1:2]] <= bus.i_imem_wdata;
    end

    assign fetch_word = imem[pc[AW+1:2]];
    assign pc_plus4   = pc + 32'd4;

    always_comb begin
        state_nx   = state;
        pc_nx      = pc_plus4;
        instr_nx   = fetch_word;
        next_pc_nx = pc_plus4;
        valid_nx   = 1'b1;
        if (bus.i_mispredict) begin
            state_nx   = RUN;
            pc_nx      = bus.i_correct_pc;
            instr_nx   = 32'h0;
            next_pc_nx = 32'h0;
            valid_nx   = 1'b0;
        end else if (bus.i_stall) begin
            pc_nx      = pc;
            instr_nx   = instr;
            next_pc_nx = next_pc;
            valid_nx   = valid;
        end else if (state == HALT) begin
            pc_nx      = pc;
            instr_nx   = 32'h0;
            next_pc_nx = 32'h0;
            valid_nx   = 1'b0;
        end else if (bus.i_branch_prediction) begin
            pc_nx      = bus.i_branch_target_addr;
            instr_nx   = 32'h0;
            next_pc_nx = 32'h0;
            valid_nx   = 1'b0;
        end else if (fetch_word == HALT_WORD) begin
            // The halt word itself goes down the pipe; PC parks on it.
            state_nx = HALT;
            pc_nx    = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            pc      <= 32'h0;
            instr   <= 32'h0;
            next_pc <= 32'h0;
            valid   <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            instr   <= instr_nx;
            next_pc <= next_pc_nx;
            valid   <= valid_nx;
        end
    end

    assign bus.o_instruction = instr;
    assign bus.o_next_pc     = next_pc;
    assign bus.o_valid       = valid;
    assign bus.o_pc          = pc;
    assign bus.o_halted      = (state == HALT);
endmodule
